// File: rtl/axis_test_pattern_generator.sv
// rtl/axis_test_pattern_generator.sv - rate-limited AXI4-Stream counting-pattern master
module axis_test_pattern_generator #(
   parameter int unsigned M_AXIS_TDATA_WIDTH = 32,
   parameter int unsigned M_AXIS_BURSTSIZE   = 0,
   parameter int unsigned COUNTER_START      = 0,
   parameter int unsigned COUNTER_END        = 255,
   parameter int unsigned COUNTER_INCR       = 1,
   parameter int unsigned DIVIDER            = 1
) (
   input  logic                          m_axis_aclk,
   input  logic                          m_axis_areset,
   input  logic                          enable,
   output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast
);
   localparam int unsigned W       = M_AXIS_TDATA_WIDTH;
   localparam int unsigned WX      = W + 1;
   localparam int unsigned DIV_EFF = (DIVIDER == 0) ? 1 : DIVIDER;
   localparam int unsigned PW      = (DIV_EFF > 1) ? $clog2(DIV_EFF) : 1;
   localparam int unsigned BW      = (M_AXIS_BURSTSIZE > 1) ? $clog2(M_AXIS_BURSTSIZE) : 1;

   localparam logic [W-1:0]  START_V = W'(COUNTER_START);
   localparam logic [W:0]    END_X   = WX'(COUNTER_END);
   localparam logic [W:0]    INCR_X  = WX'(COUNTER_INCR);
   localparam logic [PW-1:0] P_LAST  = PW'(DIV_EFF - 1);
   localparam logic [BW-1:0] B_LAST  = BW'((M_AXIS_BURSTSIZE == 0) ? 0 : M_AXIS_BURSTSIZE - 1);

   // The extra sum bit catches overflow of the data width as well as passing END.
   function automatic logic wraps(input logic [W-1:0] d);
      logic [W:0] s;
      s = {1'b0, d} + INCR_X;
      return s[W] || (s > END_X);
   endfunction

   function automatic logic [W-1:0] advance(input logic [W-1:0] d);
      logic [W:0] s;
      s = {1'b0, d} + INCR_X;
      return wraps(d) ? START_V : s[W-1:0];
   endfunction

   function automatic logic last_for(input logic [W-1:0] d, input logic [BW-1:0] b);
      if (M_AXIS_BURSTSIZE == 0) return wraps(d);
      return b == B_LAST;
   endfunction

   logic [PW-1:0] p_q, p_d;
   logic          tick_q, tick_d;
   logic          valid_q, valid_d;
   logic [W-1:0]  data_q, data_d;
   logic [BW-1:0] b_q, b_d;
   logic          last_q, last_d;
   logic          accept, launch;

   // The tick is registered, so a launch lands DIVIDER edges after the
   // prescaler starts counting from 0.
   always_comb begin
      accept  = valid_q & m_axis_tready;
      launch  = enable & tick_q & (~valid_q | accept);
      tick_d  = enable & (p_q == P_LAST);
      p_d     = '0;
      if (enable && (p_q != P_LAST)) p_d = p_q + 1'b1;
      valid_d = launch | (valid_q & ~accept);
      data_d  = accept ? advance(data_q) : data_q;
      b_d     = b_q;
      if (accept) b_d = (b_q == B_LAST) ? '0 : b_q + 1'b1;
      last_d  = last_for(data_d, b_d);
   end

   always_ff @(posedge m_axis_aclk) begin
      if (m_axis_areset) begin
         p_q     <= '0;
         tick_q  <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= START_V;
         b_q     <= '0;
         last_q  <= last_for(START_V, '0);
      end else begin
         p_q     <= p_d;
         tick_q  <= tick_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         b_q     <= b_d;
         last_q  <= last_d;
      end
   end

   assign m_axis_tdata  = data_q;
   assign m_axis_tvalid = valid_q;
   assign m_axis_tlast  = last_q;
endmodule

// File: tb/tb_axis_test_pattern_generator.sv
// tb/tb_axis_test_pattern_generator.sv - directed vectors for axis_test_pattern_generator
module tb_axis_test_pattern_generator;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, en_a, rdy_a, valid_a, last_a;
   logic [7:0] data_a;
   logic       rst_b, en_b, rdy_b, valid_b, last_b;
   logic [7:0] data_b;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       rst;
      logic       en;
      logic       rdy;
      logic       valid;
      logic [7:0] data;
      logic       last;
   } vec_t;

   vec_t va[48];
   vec_t vb[16];
   int   na, nb;
   logic found;

   axis_test_pattern_generator #(
      .M_AXIS_TDATA_WIDTH(8), .M_AXIS_BURSTSIZE(0), .COUNTER_START(0),
      .COUNTER_END(10), .COUNTER_INCR(1), .DIVIDER(3)
   ) dut_a (
      .m_axis_aclk(clk), .m_axis_areset(rst_a), .enable(en_a),
      .m_axis_tdata(data_a), .m_axis_tvalid(valid_a),
      .m_axis_tready(rdy_a), .m_axis_tlast(last_a)
   );

   axis_test_pattern_generator #(
      .M_AXIS_TDATA_WIDTH(8), .M_AXIS_BURSTSIZE(2), .COUNTER_START(2),
      .COUNTER_END(9), .COUNTER_INCR(3), .DIVIDER(1)
   ) dut_b (
      .m_axis_aclk(clk), .m_axis_areset(rst_b), .enable(en_b),
      .m_axis_tdata(data_b), .m_axis_tvalid(valid_b),
      .m_axis_tready(rdy_b), .m_axis_tlast(last_b)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input bit sel, input logic r, input logic e, input logic y);
      @(negedge clk);
      if (!sel) begin
         rst_a = r; en_a = e; rdy_a = y;
      end else begin
         rst_b = r; en_b = e; rdy_b = y;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string name, input logic v, input logic [7:0] d, input logic l);
      chk({name, ".tvalid"}, {7'd0, valid_a}, {7'd0, v});
      chk({name, ".tdata"}, data_a, d);
      chk({name, ".tlast"}, {7'd0, last_a}, {7'd0, l});
   endtask

   task automatic chk_b(input string name, input logic v, input logic [7:0] d, input logic l);
      chk({name, ".tvalid"}, {7'd0, valid_b}, {7'd0, v});
      chk({name, ".tdata"}, data_b, d);
      chk({name, ".tlast"}, {7'd0, last_b}, {7'd0, l});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1);
   end

   initial begin
      rst_a = 1'b1; en_a = 1'b0; rdy_a = 1'b0;
      rst_b = 1'b1; en_b = 1'b0; rdy_b = 1'b0;

      // Unit A: value k is offered on edge 3+3k after release, tlast rides with value 10.
      na = 0;
      for (int i = 0; i < 2; i++) begin
         va[na] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0};
         na++;
      end
      for (int n = 0; n < 40; n++) begin
         int cnt;
         cnt = (n >= 1) ? (n - 1) / 3 : 0;
         va[na] = '{1'b0, 1'b1, 1'b1, (n >= 3 && n % 3 == 0), 8'(cnt % 11), (cnt % 11 == 10)};
         na++;
      end

      nb = 0;
      vb[nb] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd2, 1'b0}; nb++;
      vb[nb] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd2, 1'b0}; nb++;
      vb[nb] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 1'b0}; nb++;
      vb[nb] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd2, 1'b0}; nb++;
      vb[nb] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd5, 1'b1}; nb++;
      vb[nb] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd8, 1'b0}; nb++;
      vb[nb] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd2, 1'b1}; nb++;
      vb[nb] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd5, 1'b0}; nb++;
      vb[nb] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd8, 1'b1}; nb++;
      vb[nb] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd2, 1'b0}; nb++;
      vb[nb] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 1'b0}; nb++;
      vb[nb] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 1'b0}; nb++;
      vb[nb] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd5, 1'b1}; nb++;
      vb[nb] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd8, 1'b0}; nb++;
      vb[nb] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd2, 1'b1}; nb++;

      for (int i = 0; i < na; i++) begin
         step(1'b0, va[i].rst, va[i].en, va[i].rdy);
         chk_a($sformatf("A.vec%0d", i), va[i].valid, va[i].data, va[i].last);
      end

      // Reset pulse while the stream is at value 6.
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         step(1'b0, 1'b0, 1'b1, 1'b1);
         if (valid_a && data_a == 8'd6) found = 1'b1;
      end
      chk("midrst.reach6", {7'd0, found}, 8'd1);
      for (int k = 0; k < 2; k++) begin
         step(1'b0, 1'b1, 1'b1, 1'b1);
         chk_a($sformatf("midrst.in%0d", k), 1'b0, 8'd0, 1'b0);
      end
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0, 1'b1, 1'b1);
         chk_a($sformatf("midrst.rel%0d", k), 1'b0, 8'd0, 1'b0);
      end
      step(1'b0, 1'b0, 1'b1, 1'b1);
      chk_a("midrst.first", 1'b1, 8'd0, 1'b0);

      // tready rattling during reset, then beat 0 held until accepted.
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b1, 1'b1, k[0]);
         chk_a($sformatf("rdyrst.in%0d", k), 1'b0, 8'd0, 1'b0);
      end
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0);
         chk($sformatf("rdyrst.rel%0d.tvalid", k), {7'd0, valid_a}, 8'd0);
      end
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0);
         chk_a($sformatf("rdyrst.hold%0d", k), 1'b1, 8'd0, 1'b0);
      end
      step(1'b0, 1'b0, 1'b1, 1'b1);
      chk("rdyrst.after_accept.tdata", data_a, 8'd1);
      found = valid_a;
      for (int k = 0; k < 3 && !found; k++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0);
         found = valid_a;
      end
      chk("rdyrst.next_beat", {7'd0, found}, 8'd1);
      chk("rdyrst.next_beat.tdata", data_a, 8'd1);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      chk("rdyrst.second_accept.tdata", data_a, 8'd2);

      // 15-cycle stall on value 4.
      step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      found = 1'b0;
      for (int k = 0; k < 30 && !found; k++) begin
         step(1'b0, 1'b0, 1'b1, 1'b1);
         if (valid_a && data_a == 8'd4) found = 1'b1;
      end
      chk("stall.reach4", {7'd0, found}, 8'd1);
      for (int k = 0; k < 15; k++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0);
         chk_a($sformatf("stall.hold%0d", k), 1'b1, 8'd4, 1'b0);
      end
      step(1'b0, 1'b0, 1'b1, 1'b1);
      chk("stall.accept.tdata", data_a, 8'd5);
      found = valid_a;
      for (int k = 0; k < 3 && !found; k++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0);
         found = valid_a;
      end
      chk("stall.next_within3", {7'd0, found}, 8'd1);
      chk("stall.next.tdata", data_a, 8'd5);

      // enable low for 25 cycles with a beat pending.
      step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         step(1'b0, 1'b0, 1'b1, 1'b1);
         if (valid_a && data_a == 8'd2) found = 1'b1;
      end
      chk("en.reach2", {7'd0, found}, 8'd1);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0);
         chk_a($sformatf("en.pending%0d", k), 1'b1, 8'd2, 1'b0);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk_a("en.accept", 1'b0, 8'd3, 1'b0);
      for (int k = 0; k < 21; k++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         chk_a($sformatf("en.off%0d", k), 1'b0, 8'd3, 1'b0);
      end
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0, 1'b1, 1'b1);
         chk($sformatf("en.resume%0d.tvalid", k), {7'd0, valid_a}, 8'd0);
      end
      step(1'b0, 1'b0, 1'b1, 1'b1);
      chk_a("en.resume_beat", 1'b1, 8'd3, 1'b0);

      // Unit B: back-to-back, wrap 8->2, tlast on every second accepted beat.
      for (int i = 0; i < nb; i++) begin
         step(1'b1, vb[i].rst, vb[i].en, vb[i].rdy);
         chk_b($sformatf("B.vec%0d", i), vb[i].valid, vb[i].data, vb[i].last);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
